// File: rtl/wb_timer_ctrl.sv
// ---------------------------------------------------------------------------
// wb_timer_ctrl
//
// Wishbone-controlled sequencer for a down-counting timer. Firmware programs
// a reload value, a mode and an interrupt enable, then starts and stops the
// counter through four word registers (adr[3:2]):
//   0 CTRL   : bit0 EN, bit1 PERIODIC, bit2 IRQ_EN
//   1 RELOAD : [BITS-1:0]
//   2 COUNT  : read live count, write loads it
//   3 STATUS : bit0 EXPIRED (sticky, write-1-to-clear), bit1 RUNNING (RO)
//
// Handshake: a request is valid while wbs_cyc_i & wbs_stb_i. It is accepted
// on a clk edge where valid is high and wbs_ack_o is low. On that edge
// wbs_ack_o rises for exactly one cycle, read data for the addressed
// register is registered onto wbs_dat_o, and any write takes effect. Since
// acceptance requires ack low, ack is never high on two consecutive cycles.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   wbs_*             Wishbone slave (cyc, stb, we, sel, adr, dat_i/ack/dat_o)
//   la_load/la_value  logic-analyzer load of the count register
//   count_o           current count
//   running_o         high while the FSM is in RUN
//   irq_o             level interrupt, EXPIRED & IRQ_EN
//   o_dbg_state       FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module wb_timer_ctrl #(
    parameter int unsigned     BITS         = 32,
    parameter logic [BITS-1:0] RESET_RELOAD = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic            la_load,
    input  logic [BITS-1:0] la_value,
    output logic [BITS-1:0] count_o,
    output logic            running_o,
    output logic            irq_o,
    output logic [1:0]      o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_ack;
    logic [31:0]     r_dat;
    logic            r_en;
    logic            r_periodic;
    logic            r_irq_en;
    logic            r_expired;
    logic [BITS-1:0] r_reload;
    logic [BITS-1:0] r_count;

    logic            w_access;
    logic            w_wr;
    logic [1:0]      w_addr;
    logic            w_ctrl_wr;
    logic            w_reload_wr;
    logic            w_count_wr;
    logic            w_status_w1c;
    logic            w_en_rise;
    logic            w_en_fall;
    logic [31:0]     w_reload_ext;
    logic [31:0]     w_count_ext;
    logic [31:0]     w_reload_merged;
    logic [31:0]     w_count_merged;
    logic [BITS-1:0] w_reload_next;
    logic [BITS-1:0] w_count_next;
    logic [31:0]     w_rd_data;
    logic            w_set_exp;
    logic            w_clr_en;
    logic            w_unused_ok;

    // Byte-lane write merge: lanes with sel low keep the old value.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    // ---------------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------------
    assign w_access     = wbs_cyc_i & wbs_stb_i & ~r_ack;
    assign w_wr         = w_access & wbs_we_i;
    assign w_addr       = wbs_adr_i[3:2];
    assign w_ctrl_wr    = w_wr & (w_addr == 2'd0) & wbs_sel_i[0];
    assign w_reload_wr  = w_wr & (w_addr == 2'd1);
    assign w_count_wr   = w_wr & (w_addr == 2'd2);
    assign w_status_w1c = w_wr & (w_addr == 2'd3) & wbs_sel_i[0] & wbs_dat_i[0];
    assign w_en_rise    = w_ctrl_wr & wbs_dat_i[0] & ~r_en;
    assign w_en_fall    = w_ctrl_wr & ~wbs_dat_i[0];

    // Zero-extend the BITS-wide registers to the 32-bit bus width.
    always_comb begin
        w_reload_ext             = '0;
        w_reload_ext[BITS-1:0]   = r_reload;
        w_count_ext              = '0;
        w_count_ext[BITS-1:0]    = r_count;
    end

    assign w_reload_merged = byte_merge(w_reload_ext, wbs_dat_i, wbs_sel_i);
    assign w_count_merged  = byte_merge(w_count_ext, wbs_dat_i, wbs_sel_i);

    // A start in the same access as a RELOAD write sees the new value.
    assign w_reload_next = w_reload_wr ? w_reload_merged[BITS-1:0] : r_reload;

    // Address bits above/below the word index and merge bits beyond BITS
    // carry no information here.
    assign w_unused_ok = ^{wbs_adr_i[31:4], wbs_adr_i[1:0],
                           w_reload_merged, w_count_merged};

    // Read data mux (pre-write values of the addressed register).
    always_comb begin
        w_rd_data = '0;
        case (w_addr)
            2'd0:    w_rd_data[2:0] = {r_irq_en, r_periodic, r_en};
            2'd1:    w_rd_data      = w_reload_ext;
            2'd2:    w_rd_data      = w_count_ext;
            default: w_rd_data[1:0] = {running_o, r_expired};
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM and count path
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_set_exp    = 1'b0;
        w_clr_en     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_en_rise) begin
                    w_state_next = ST_RUN;
                    w_count_next = w_reload_next;
                end else begin
                    if (w_en_fall) w_state_next = ST_IDLE;
                    if (w_count_wr)   w_count_next = w_count_merged[BITS-1:0];
                    else if (la_load) w_count_next = la_value;
                end
            end
            ST_RUN: begin
                if (w_en_fall) w_state_next = ST_IDLE;
                // Any explicit load takes the cycle; no decrement or expiry.
                if (w_count_wr) begin
                    w_count_next = w_count_merged[BITS-1:0];
                end else if (la_load) begin
                    w_count_next = la_value;
                end else if (!w_en_fall) begin
                    if (r_count == '0) begin
                        w_set_exp = 1'b1;
                        if (r_periodic) begin
                            w_count_next = r_reload;
                        end else begin
                            w_state_next = ST_DONE;
                            w_clr_en     = 1'b1;
                        end
                    end else begin
                        w_count_next = r_count - BITS'(1);
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Register file
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_en       <= 1'b0;
            r_periodic <= 1'b0;
            r_irq_en   <= 1'b0;
            r_expired  <= 1'b0;
            r_reload   <= RESET_RELOAD;
            r_count    <= '0;
        end else begin
            r_ack <= w_access;
            if (w_access) r_dat <= w_rd_data;
            if (w_ctrl_wr) begin
                r_en       <= wbs_dat_i[0];
                r_periodic <= wbs_dat_i[1];
                r_irq_en   <= wbs_dat_i[2];
            end
            // One-shot expiry overrides a concurrent CTRL write of EN.
            if (w_clr_en) r_en <= 1'b0;
            r_reload <= w_reload_next;
            r_count  <= w_count_next;
            // Set wins over a same-edge write-1-to-clear.
            if (w_set_exp)         r_expired <= 1'b1;
            else if (w_status_w1c) r_expired <= 1'b0;
        end
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign count_o     = r_count;
    assign running_o   = (r_state == ST_RUN);
    assign irq_o       = r_expired & r_irq_en;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wb_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_timer_ctrl
//
// Directed bench for wb_timer_ctrl. A 32-bit instance carries the main
// sequence; a 16-bit instance shares the same inputs so the narrow read-back
// of RELOAD can be compared on the same accesses.
// ---------------------------------------------------------------------------
module tb_wb_timer_ctrl;

    // Clock / reset ----------------------------------------------------------
    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    // Stimulus ---------------------------------------------------------------
    logic        cyc      = 1'b0;
    logic        stb      = 1'b0;
    logic        we       = 1'b0;
    logic [3:0]  sel      = 4'h0;
    logic [31:0] adr      = 32'h0;
    logic [31:0] dat_i    = 32'h0;
    logic        la_load  = 1'b0;
    logic [31:0] la_value = 32'h0;

    // DUT outputs ------------------------------------------------------------
    logic        ack, running, irq;
    logic [31:0] dat_o, count;
    logic [1:0]  dbg;
    logic        ack16, running16, irq16;
    logic [31:0] dat16;
    logic [15:0] count16;
    logic [1:0]  dbg16;

    wb_timer_ctrl #(.BITS(32)) u_dut (
        .clk(clk), .reset(reset),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .la_load(la_load), .la_value(la_value),
        .count_o(count), .running_o(running), .irq_o(irq),
        .o_dbg_state(dbg)
    );

    wb_timer_ctrl #(.BITS(16)) u_dut16 (
        .clk(clk), .reset(reset),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i),
        .wbs_ack_o(ack16), .wbs_dat_o(dat16),
        .la_load(la_load), .la_value(la_value[15:0]),
        .count_o(count16), .running_o(running16), .irq_o(irq16),
        .o_dbg_state(dbg16)
    );

    // Scoreboard counters -----------------------------------------------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [31:0] rd;
    logic [31:0] rd16;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver tasks -------------------------------------------------------------
    // Called at posedge+1. If the previous access was just acknowledged the
    // bus needs one idle edge before a new request can be accepted.
    task automatic wb_xfer(input logic w, input logic [1:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] r);
        int waited;
        if (ack) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w;
        adr = {28'h0, a, 2'b00}; dat_i = d; sel = s;
        @(posedge clk); #1;
        check("ack_latency", {31'b0, ack}, 32'd1);
        waited = 0;
        while (!ack && waited < 4) begin
            @(posedge clk); #1;
            waited++;
        end
        r    = dat_o;
        rd16 = dat16;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        logic [31:0] unused_r;
        wb_xfer(1'b1, a, d, s, unused_r);
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] r);
        wb_xfer(1'b0, a, 32'h0, 4'hf, r);
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Watchdog ------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Directed sequence -----------------------------------------------------------
    initial begin
        // 1. Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",     {31'b0, ack},     32'd0);
        check("rst_dat",     dat_o,            32'd0);
        check("rst_count",   count,            32'd0);
        check("rst_running", {31'b0, running}, 32'd0);
        check("rst_irq",     {31'b0, irq},     32'd0);
        check("rst_state",   {30'b0, dbg},     32'd0);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            wb_read(a[1:0], rd);
            check("rst_read", rd, 32'd0);
        end
        tick();
        // Held request: ack must go 1, 0, 1.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hf;
        tick(); check("b2b_ack0", {31'b0, ack}, 32'd1);
        tick(); check("b2b_ack1", {31'b0, ack}, 32'd0);
        tick(); check("b2b_ack2", {31'b0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0;

        // 2. One-shot
        wb_write(2'd1, 32'd5, 4'hf);
        wb_write(2'd0, 32'h5, 4'hf);
        check("os_count5", count, 32'd5);
        check("os_run",    {31'b0, running}, 32'd1);
        for (int k = 4; k >= 0; k--) begin
            tick();
            check("os_count", count, k);
        end
        tick();
        check("os_done_running", {31'b0, running}, 32'd0);
        check("os_done_irq",     {31'b0, irq},     32'd1);
        check("os_done_count",   count,            32'd0);
        check("os_done_state",   {30'b0, dbg},     32'd2);
        wb_read(2'd3, rd);
        check("os_status", rd, 32'h1);
        wb_read(2'd0, rd);
        check("os_ctrl_en_clr", rd, 32'h4);
        check("os_hold0", count, 32'd0);
        wb_write(2'd3, 32'h1, 4'hf);
        check("os_w1c_irq", {31'b0, irq}, 32'd0);
        wb_write(2'd0, 32'h0, 4'hf);
        check("os_done_to_idle", {30'b0, dbg}, 32'd0);

        // 3. Periodic (IRQ_EN on so each expiry is visible on irq)
        wb_write(2'd1, 32'd2, 4'hf);
        wb_write(2'd0, 32'h7, 4'hf);
        check("per_count0", count, 32'd2);
        check("per_irq0",   {31'b0, irq}, 32'd0);
        begin
            logic [31:0] exp_cnt [6] = '{1, 0, 2, 1, 0, 2};
            logic [31:0] exp_irq [6] = '{0, 0, 1, 1, 1, 1};
            for (int k = 0; k < 6; k++) begin
                tick();
                check("per_count", count, exp_cnt[k]);
                check("per_irq",   {31'b0, irq}, exp_irq[k]);
            end
        end
        wb_write(2'd3, 32'h1, 4'h1);
        check("per_w1c_count", count, 32'd1);
        check("per_w1c_irq",   {31'b0, irq}, 32'd0);
        tick();
        check("per_count_b", count, 32'd0);
        tick();
        check("per_count_c", count, 32'd2);
        check("per_irq_c",   {31'b0, irq}, 32'd1);
        wb_write(2'd0, 32'h0, 4'hf);
        check("per_stop_count",   count, 32'd2);
        check("per_stop_running", {31'b0, running}, 32'd0);
        tick();
        check("per_stop_hold", count, 32'd2);
        wb_write(2'd3, 32'h1, 4'hf);
        wb_read(2'd3, rd);
        check("per_status_clr", rd, 32'h0);

        // 4. Arbitration
        wb_write(2'd1, 32'h1000, 4'hf);
        wb_write(2'd0, 32'h1, 4'hf);
        check("arb_start", count, 32'h1000);
        tick();
        check("arb_dec", count, 32'h0FFF);
        la_load = 1'b1; la_value = 32'h100;
        wb_write(2'd2, 32'h55, 4'hf);
        check("arb_wb_wins", count, 32'h55);
        tick();
        check("arb_la", count, 32'h100);
        la_load = 1'b0;
        tick();
        check("arb_resume", count, 32'h0FF);
        wb_write(2'd0, 32'h0, 4'hf);
        check("arb_stop", count, 32'h0FF);
        la_load = 1'b1; la_value = 32'h33;
        tick();
        la_load = 1'b0;
        check("arb_la_idle",       count, 32'h33);
        check("arb_la_idle_state", {30'b0, dbg}, 32'd0);

        // 5. Byte strobes
        wb_write(2'd1, 32'h0, 4'hf);
        wb_write(2'd1, 32'hAABBCCDD, 4'b0101);
        wb_read(2'd1, rd);
        check("sel_reload32", rd,   32'h00BB00DD);
        check("sel_reload16", rd16, 32'h000000DD);

        // 6a. Reset during RUN with a pending write
        wb_write(2'd1, 32'h1, 4'hf);
        wb_write(2'd0, 32'h3, 4'hf);
        wb_read(2'd1, rd);
        check("mid_pre_read", rd, 32'h1);
        repeat (2) tick();
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h8;
        dat_i = 32'h77; sel = 4'hf; reset = 1'b1;
        tick();
        check("mid_ack",     {31'b0, ack},     32'd0);
        check("mid_dat",     dat_o,            32'd0);
        check("mid_count",   count,            32'd0);
        check("mid_running", {31'b0, running}, 32'd0);
        check("mid_state",   {30'b0, dbg},     32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; reset = 1'b0;
        tick();
        check("mid_ack_after", {31'b0, ack}, 32'd0);
        wb_read(2'd0, rd);
        check("mid_ctrl", rd, 32'h0);
        wb_read(2'd2, rd);
        check("mid_count_rd", rd, 32'h0);
        wb_read(2'd3, rd);
        check("mid_status", rd, 32'h0);

        // 6b. Expiry every cycle; W1C coincident with expiry
        wb_write(2'd1, 32'h0, 4'hf);
        wb_write(2'd0, 32'h7, 4'hf);
        tick();
        check("z_irq",     {31'b0, irq},     32'd1);
        check("z_count",   count,            32'd0);
        check("z_running", {31'b0, running}, 32'd1);
        wb_write(2'd3, 32'h1, 4'hf);
        check("z_w1c_set_wins", {31'b0, irq}, 32'd1);
        wb_read(2'd3, rd);
        check("z_status", rd, 32'h3);
        wb_write(2'd0, 32'h0, 4'hf);
        check("z_stopped", {31'b0, running}, 32'd0);

        // Report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_timer_ctrl.md
Name: wb_timer_ctrl

Overview:
Wishbone-controlled sequencer for a down-counting timer datapath in the user project area. Management SoC firmware configures the reload value, mode and interrupt enable, then starts, stops and reloads the counter through four registers. The block also arbitrates count-register writes between the Wishbone bus, a logic-analyzer load port and the internal decrement, and raises a level interrupt on expiry.

Parameters:
BITS, 32, counter width, 1..32. Unused upper read-data bits return 0.
RESET_RELOAD, 0, RELOAD register value after reset.

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
wbs_cyc_i  input  1  Wishbone cycle
wbs_stb_i  input  1  Wishbone strobe
wbs_we_i  input  1  write enable
wbs_sel_i  input  4  byte strobes
wbs_adr_i  input  32  address; only bits [3:2] decoded (base decode is done upstream)
wbs_dat_i  input  32  write data
wbs_ack_o  output  1  acknowledge
wbs_dat_o  output  32  read data, registered
la_load  input  1  LA request to load the count register
la_value  input  BITS  LA load value
count_o  output  BITS  current count
running_o  output  1  high when the FSM is in RUN
irq_o  output  1  level interrupt

Behaviour:
- Register map (adr[3:2]):
  - 0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN.
  - 1 RELOAD [BITS-1:0].
  - 2 COUNT: read returns the live count; write loads it.
  - 3 STATUS: bit0 EXPIRED (sticky, write-1-to-clear), bit1 RUNNING (read-only).
- Writes honour wbs_sel_i per byte.
- Handshake: valid = cyc & stb. On a clk edge with valid & !ack, the block:
  - sets ack = 1 for exactly one cycle;
  - captures read data into wbs_dat_o;
  - performs the write, if any.
  - ack is never asserted on two consecutive cycles. Single-access latency is 1 cycle.
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
  - IDLE/DONE -> RUN: write sets EN 0->1. On the same edge count is loaded from RELOAD, using the post-write RELOAD value if RELOAD is written in that access.
  - RUN, count != 0: count decrements by 1 each cycle.
  - RUN, count == 0, PERIODIC = 1: EXPIRED set, count <= RELOAD, stay in RUN.
  - RUN, count == 0, PERIODIC = 0: EXPIRED set, EN cleared, go to DONE, count holds 0.
  - RUN -> IDLE: write clears EN. count holds its value.
  - DONE -> IDLE: write of EN = 0. Otherwise DONE holds.
- Count write priority, highest first: Wishbone COUNT write, then la_load, then expiry reload, then decrement. A Wishbone or LA load in RUN suppresses that cycle's decrement and expiry check. LA loads are accepted in any state.
- EXPIRED: a set event and a W1C on the same edge -> set wins.
- irq_o = EXPIRED & IRQ_EN, combinational from registered bits.
- Arithmetic: modulo 2^BITS. Decrement is never applied at 0. RELOAD = 0 with PERIODIC = 1 gives an expiry every cycle.
- Reset: synchronous and valid mid-transaction. All of the following return to reset values: ack, CTRL, STATUS, count, FSM, wbs_dat_o.
- Reset values: wbs_ack_o = 0, wbs_dat_o = 0, count_o = 0, running_o = 0, irq_o = 0, RELOAD = RESET_RELOAD.
- An access in flight during reset is dropped with no ack.
- cyc or stb deasserting before ack: no side effect, provided it deasserts before the sampling edge.

Test Plan:
1. Reset state: after reset, read all 4 registers -> 0, 0 (RESET_RELOAD), 0, 0. ack is 1 cycle after stb each time, and is never high on back-to-back cycles.
2. One-shot: RELOAD = 5, CTRL = 0x5.
   - count_o reads 5, 4, 3, 2, 1, 0 on successive cycles.
   - Then EXPIRED = 1, EN = 0, running_o = 0, irq_o = 1, and count holds 0.
   - W1C STATUS = 1 -> irq_o = 0.
3. Periodic: RELOAD = 2, CTRL = 0x3 -> count sequence 2, 1, 0, 2, 1, 0 ... with EXPIRED set at each 0. Writing CTRL = 0 stops the count at its current value.
4. Arbitration: in RUN, la_load = 1 with la_value = 0x100 on the same edge as a WB COUNT write of 0x55 -> count = 0x55. The next cycle, la_load alone -> count = 0x100, then decrementing resumes.
5. Byte strobes: write RELOAD = 0xAABBCCDD with sel = 4'b0101 over RELOAD = 0 -> reads 0x00BB00DD. With BITS = 16, the read returns 0x000000DD.
6. Corner cases:
   - Reset asserted during RUN with a pending WB write -> no ack, all registers reset.
   - Expiry coincident with a W1C of EXPIRED -> EXPIRED stays 1.
